// File: rtl/dense_logit_argmax_reader.sv
// Final dense-layer consumer: starts the layer, reads NUM_CLASSES signed logits and reports the argmax.
// Optional feature macro LOGIT_CAPTURE_EN keeps a readable copy of every sampled logit.
module dense_logit_argmax_reader #(
    parameter int NUM_CLASSES = 9,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cls_start,
    output logic              cls_busy,
    output logic              cls_valid,
    output logic              cls_err,
    output logic [ADDR_W-1:0] class_id,
    output logic [DATA_W-1:0] class_score,
    output logic              layer_start,
    input  logic              layer_done,
    output logic [ADDR_W-1:0] layer_read_addr,
    input  logic [DATA_W-1:0] layer_read_data
`ifdef LOGIT_CAPTURE_EN
    ,
    input  logic [ADDR_W-1:0] logit_sel,
    output logic [DATA_W-1:0] logit_out
`endif
);

    localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(NUM_CLASSES - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_READ      = 3'd3,
        S_RESULT    = 3'd4,
        S_TIMEOUT   = 3'd5
    } state_t;

    state_t               state_r;
    logic [TIMEOUT_W-1:0] wait_cnt_r;
    logic [TIMEOUT_W-1:0] wait_cnt_inc_s;
    logic [ADDR_W-1:0]    rd_idx_r;
    logic [DATA_W-1:0]    max_val_r;
    logic [ADDR_W-1:0]    max_idx_r;
    logic                 data_gt_s;
    logic                 take_s;

    // Strict signed compare so ties keep the earliest class index.
    always_comb begin
        wait_cnt_inc_s = wait_cnt_r + TIMEOUT_W'(1);
        data_gt_s      = $signed(layer_read_data) > $signed(max_val_r);
        if (rd_idx_r == {ADDR_W{1'b0}}) begin
            take_s = 1'b1;
        end else begin
            take_s = data_gt_s;
        end
    end

    // Sequencer: start pulse, bounded wait for done, logit sweep, result/timeout report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            wait_cnt_r      <= {TIMEOUT_W{1'b0}};
            rd_idx_r        <= {ADDR_W{1'b0}};
            max_val_r       <= {DATA_W{1'b0}};
            max_idx_r       <= {ADDR_W{1'b0}};
            cls_busy        <= 1'b0;
            cls_valid       <= 1'b0;
            cls_err         <= 1'b0;
            class_id        <= {ADDR_W{1'b0}};
            class_score     <= {DATA_W{1'b0}};
            layer_start     <= 1'b0;
            layer_read_addr <= {ADDR_W{1'b0}};
        end else begin
            layer_start <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (cls_start) begin
                        state_r         <= S_START;
                        cls_busy        <= 1'b1;
                        cls_valid       <= 1'b0;
                        cls_err         <= 1'b0;
                        wait_cnt_r      <= {TIMEOUT_W{1'b0}};
                        layer_read_addr <= {ADDR_W{1'b0}};
                        layer_start     <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                // layer_done is deliberately not looked at here: a level left over from
                // the previous run must not satisfy the new wait.
                S_START: begin
                    state_r <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (layer_done) begin
                        state_r  <= S_READ;
                        rd_idx_r <= {ADDR_W{1'b0}};
                    end else begin
                        wait_cnt_r <= wait_cnt_inc_s;
                        if (wait_cnt_inc_s == CNT_MAX) begin
                            state_r <= S_TIMEOUT;
                        end else begin
                            state_r <= S_WAIT_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (take_s) begin
                        max_val_r <= layer_read_data;
                        max_idx_r <= rd_idx_r;
                    end else begin
                        max_val_r <= max_val_r;
                    end
                    if (rd_idx_r == LAST_IDX) begin
                        state_r <= S_RESULT;
                    end else begin
                        rd_idx_r        <= rd_idx_r + ADDR_W'(1);
                        layer_read_addr <= rd_idx_r + ADDR_W'(1);
                    end
                end
                S_RESULT: begin
                    class_id    <= max_idx_r;
                    class_score <= max_val_r;
                    cls_valid   <= 1'b1;
                    cls_busy    <= 1'b0;
                    state_r     <= S_IDLE;
                end
                S_TIMEOUT: begin
                    cls_err  <= 1'b1;
                    cls_busy <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    cls_busy <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOGIT_CAPTURE_EN
    logic [DATA_W-1:0] logit_file_r [0:NUM_CLASSES-1];

    // Shadow every logit sampled during the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                logit_file_r[i] <= {DATA_W{1'b0}};
            end
        end else if (state_r == S_READ) begin
            logit_file_r[rd_idx_r] <= layer_read_data;
        end else begin
            logit_file_r[0] <= logit_file_r[0];
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        logit_out = {DATA_W{1'b0}};
        if (logit_sel <= LAST_IDX) begin
            logit_out = logit_file_r[logit_sel];
        end else begin
            logit_out = {DATA_W{1'b0}};
        end
    end
`endif

endmodule
